sram_controller: RTL and testbench

- Sequences the external 16-bit asynchronous SRAM on behalf of the MIPS memory stage.
- Converts each 32-bit load/store into two half-word SRAM accesses: low half first, then high half.
- Drives the SRAM address, write-enable, output-enable and data bus.
- Deasserts ready while an access is in progress, so the pipeline freezes until the word completes.

---
 rtl/sram_controller.sv | 119 +++++++++++
 tb/tb_sram_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Two-beat sequencer for a 16-bit asynchronous SRAM. Each 32-bit load or store
// becomes a low half-word access followed by a high half-word access, with ready low meanwhile.
module sram_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] SRAMaddress,
  output logic        SRAMWEn,
  output logic        SRAMOE,
  inout  wire  [15:0] SRAMdata
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE = 32'(ADDR_BASE);
  localparam logic [3:0]  LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [31:0] offset;
  logic        req;
  logic        phase_end;
  logic        drive;
  logic [15:0] dout;

  assign req       = MEM_R_EN | MEM_W_EN;
  assign offset    = address - BASE;
  assign phase_end = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Pins are decoded from state alone so reset releases the bus immediately.
  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    SRAMaddress = '0;
    SRAMWEn     = 1'b1;
    SRAMOE      = 1'b1;
    drive       = 1'b0;
    dout        = wdata_q[15:0];
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nxt = LOW;
      end
      LOW: begin
        SRAMaddress = {word_q, 1'b0};
        SRAMWEn     = ~wr_q;
        SRAMOE      = wr_q;
        drive       = wr_q;
        if (phase_end) state_nxt = HIGH;
      end
      HIGH: begin
        SRAMaddress = {word_q, 1'b1};
        SRAMWEn     = ~wr_q;
        SRAMOE      = wr_q;
        drive       = wr_q;
        dout        = wdata_q[31:16];
        if (phase_end) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only writes drive the bus, and writes never lower SRAMOE.
  assign SRAMdata = drive ? dout : 16'hzzzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      wr_q     <= 1'b0;
      word_q   <= '0;
      wdata_q  <= '0;
      readData <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            wr_q    <= MEM_W_EN;
            word_q  <= offset[18:2];
            wdata_q <= writeData;
          end
        end
        LOW, HIGH: begin
          if (phase_end) begin
            cnt <= '0;
            if (!wr_q) begin
              if (state == LOW) readData[15:0]  <= SRAMdata;
              else              readData[31:16] <= SRAMdata;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a WAIT_CYCLES=1 and a WAIT_CYCLES=3 instance, each with its own
// SRAM array, driven by a vector table, hand sequences and random accesses against a word-level model.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel, r_en, w_en, clr;
  logic [31:0] addr, wdata;

  wire  [15:0] busA, busB;
  logic [17:0] saA, saB;
  logic        weA, weB, oeA, oeB, rdyA, rdyB;
  logic [31:0] rdA, rdB;

  logic [15:0] memA [0:262143];
  logic [15:0] memB [0:262143];

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd  [2];

  sram_controller #(.WAIT_CYCLES(1), .ADDR_BASE(1024)) dut_a (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en & ~sel), .MEM_W_EN(w_en & ~sel),
    .address(addr), .writeData(wdata), .readData(rdA), .ready(rdyA),
    .SRAMaddress(saA), .SRAMWEn(weA), .SRAMOE(oeA), .SRAMdata(busA));

  sram_controller #(.WAIT_CYCLES(3), .ADDR_BASE(1024)) dut_b (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en & sel), .MEM_W_EN(w_en & sel),
    .address(addr), .writeData(wdata), .readData(rdB), .ready(rdyB),
    .SRAMaddress(saB), .SRAMWEn(weB), .SRAMOE(oeB), .SRAMdata(busB));

  // Asynchronous SRAM models: read data appears while OE is low, writes land at the clock edge.
  assign busA = (!oeA && weA) ? memA[saA] : 16'hzzzz;
  assign busB = (!oeB && weB) ? memB[saB] : 16'hzzzz;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 262144; i++) begin
        memA[i] <= 16'h0;
        memB[i] <= 16'h0;
      end
    end else begin
      if (!weA) memA[saA] <= busA;
      if (!weB) memB[saB] <= busB;
    end
  end

  logic        o_rdy, o_we, o_oe;
  logic [17:0] o_sa;
  logic [31:0] o_rd;
  logic [15:0] o_bus;
  assign o_rdy = sel ? rdyB : rdyA;
  assign o_we  = sel ? weB  : weA;
  assign o_oe  = sel ? oeB  : oeA;
  assign o_sa  = sel ? saB  : saA;
  assign o_rd  = sel ? rdB  : rdA;
  assign o_bus = sel ? busB : busA;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[18:2];
  endfunction

  // Write and read enables must never be low together.
  always @(negedge clk) begin
    if (rst) begin
      chk("contention_a", {31'd0, (!oeA && !weA)}, 32'd0);
      chk("contention_b", {31'd0, (!oeB && !weB)}, 32'd0);
    end
  end

  task automatic access(input bit s, input bit w, input bit r,
                        input logic [31:0] a, input logic [31:0] d);
    int          W, k, lat, key;
    bit          done;
    logic [31:0] exp_rd;
    logic [16:0] wd;
    logic [17:0] ea;
    W   = s ? 3 : 1;
    wd  = word_of(a);
    key = (s ? (1 << 20) : 0) + int'(wd);
    if (w) exp_rd = ref_rd[s];
    else   exp_rd = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    @(posedge clk); #1;
    sel = s; w_en = w; r_en = r; addr = a; wdata = d;
    k = 0; done = 0; lat = 0;
    while (!done && k < 64) begin
      @(negedge clk);
      if (o_rdy) begin
        done = 1;
        lat  = k;
      end else if (k >= 1 && k <= 2 * W) begin
        ea = {wd, (k > W)};
        chk("sram_addr", {14'd0, o_sa}, {14'd0, ea});
        chk("sram_we", {31'd0, o_we}, {31'd0, !w});
        chk("sram_oe", {31'd0, o_oe}, {31'd0, w});
        if (w) chk("sram_wdata", {16'd0, o_bus}, {16'd0, (k > W) ? d[31:16] : d[15:0]});
      end
      k++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got no ready after %0d cycles, required %0d", k, 1 + 2 * W);
    end else begin
      chk("latency", lat, 1 + 2 * W);
      chk("readData", o_rd, exp_rd);
      chk("done_pins", {12'd0, o_sa, o_we, o_oe}, {12'd0, 18'd0, 2'b11});
    end
    if (w) ref_mem[key] = d;
    ref_rd[s] = exp_rd;
    @(posedge clk); #1;
    r_en = 0; w_en = 0;
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'd1032,            32'hDEADBEEF, 32'h00000000};
    tbl[1] = '{1'b0, 1'b1, 32'd1032,            32'h00000000, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'd1024,            32'h12345678, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 32'd1024,            32'h00000000, 32'h12345678};
    tbl[4] = '{1'b0, 1'b1, 32'd1036,            32'h00000000, 32'h00000000};
    tbl[5] = '{1'b1, 1'b0, 32'd1024 + 32'h80000, 32'hCAFEF00D, 32'h00000000};
    tbl[6] = '{1'b0, 1'b1, 32'd1024,            32'h00000000, 32'hCAFEF00D};
    tbl[7] = '{1'b1, 1'b0, 32'd0,               32'h0BADF00D, 32'hCAFEF00D};
    tbl[8] = '{1'b0, 1'b1, 32'd0,               32'h00000000, 32'h0BADF00D};

    sel = 0; r_en = 0; w_en = 0; addr = 0; wdata = 0; clr = 1; rst = 0;
    ref_rd[0] = 32'h0;
    ref_rd[1] = 32'h0;
    @(posedge clk); #1;
    clr = 0;

    // Idle pins during and right after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) rst = 1;
      chk("idle_a", {rdyA, weA, oeA, saA, rdA[10:0]}, {3'b111, 18'd0, 11'd0});
      chk("idle_b", {rdyB, weB, oeB, saB, rdB[10:0]}, {3'b111, 18'd0, 11'd0});
      chk("idle_rd_a", rdA, 32'h0);
    end

    for (int i = 0; i < 9; i++) begin
      access(1'b0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      chk("tbl_readData", rdA, tbl[i].exp_rd);
      if (i == 2) begin
        chk("sram0", {16'd0, memA[0]}, 32'h5678);
        chk("sram1", {16'd0, memA[1]}, 32'h1234);
      end
    end

    // Reset asserted in the HIGH phase of a store.
    sel = 0;
    @(posedge clk); #1;
    w_en = 1; addr = 32'd1040; wdata = 32'h11112222;
    repeat (3) @(negedge clk);
    chk("high_we", {31'd0, weA}, 32'd0);
    chk("high_addr", {14'd0, saA}, 32'd9);
    rst = 0;
    #1;
    chk("rst_pins", {12'd0, saA, weA, oeA}, {12'd0, 18'd0, 2'b11});
    chk("rst_readData", rdA, 32'h0);
    chk("rst_ready_req", {31'd0, rdyA}, 32'd0);
    w_en = 0;
    #1;
    chk("rst_ready_noreq", {31'd0, rdyA}, 32'd1);
    ref_rd[0] = 32'h0;
    ref_rd[1] = 32'h0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, rdyA}, 32'd1);
    access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h0);
    chk("post_rst_load", rdA, 32'hDEADBEEF);

    // Random traffic on the slow instance; the first access is a load.
    for (int n = 0; n < 40; n++) begin
      int          t;
      logic [31:0] a;
      t = (n == 0) ? 0 : int'($urandom_range(0, 2));
      a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + (32'($urandom_range(0, 3)) << 19);
      access(1'b1, t != 0, t != 1, a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
